// File: rtl/uart_tx_top.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx_top #(
    parameter int CLKS_PER_BIT = 2,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte2send,
    input  logic       tx_start,
    output logic       tx_done,
    output logic       tx_pin
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx_pin;
    logic          r_tx_done;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic w_bit_end;
    assign w_bit_end = (r_cnt == CNT_LAST);

    assign tx_pin  = r_tx_pin;
    assign tx_done = r_tx_done;

    // tx_pin is registered: each state loads the value of the NEXT bit on the edge that enters it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx_pin  <= 1'b1;
            r_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx_pin  <= 1'b1;
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (tx_start) begin
                        r_shift  <= byte2send;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^byte2send;
`endif
                        r_tx_pin <= 1'b0;
                        r_state  <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_tx_pin <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                        r_state  <= DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        // Index parks at the last bit; IDLE clears it for the next frame.
                        if (r_bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_tx_pin <= r_parity;
                            r_state  <= PARITY;
`else
                            r_tx_pin <= 1'b1;
                            r_state  <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx_pin  <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_cnt    <= '0;
                        r_tx_pin <= 1'b1;
                        r_state  <= STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_tx_pin  <= 1'b1;
                        r_tx_done <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_pin <= 1'b1;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: queue-based waveform model checked every cycle, plus directed frames
// with literal bit patterns and tx_done latencies.
module tb_uart_tx_top;

    localparam int CPB = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [NBITS-1:0] LIT_9A = 11'b1_0_1001_1010_0;
    localparam logic [NBITS-1:0] LIT_3C = 11'b1_0_0011_1100_0;
    localparam logic [NBITS-1:0] LIT_FF = 11'b1_0_1111_1111_0;
    localparam logic [NBITS-1:0] LIT_01 = 11'b1_1_0000_0001_0;
`else
    localparam int NBITS = 10;
    localparam logic [NBITS-1:0] LIT_9A = 10'b1_1001_1010_0;
    localparam logic [NBITS-1:0] LIT_3C = 10'b1_0011_1100_0;
    localparam logic [NBITS-1:0] LIT_FF = 10'b1_1111_1111_0;
    localparam logic [NBITS-1:0] LIT_01 = 10'b1_0000_0001_0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] byte2send;
    logic       tx_done;
    logic       tx_pin;

    int total = 0;
    int bad   = 0;

    uart_tx_top #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .byte2send (byte2send),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .tx_pin    (tx_pin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted frame becomes a list of per-cycle (pin, done) values.
    bit q_pin[$];
    bit q_done[$];
    logic exp_pin  = 1'b1;
    logic exp_done = 1'b0;
    bit   model_ok = 0;

    task automatic build_frame(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < CPB; c++) begin
                q_pin.push_back(bits[k]);
                q_done.push_back(1'b0);
            end
        end
        q_pin.push_back(1'b1);
        q_done.push_back(1'b1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q_pin.delete();
            q_done.delete();
            exp_pin  = 1'b1;
            exp_done = 1'b0;
            model_ok = 1;
        end else begin
            if (q_pin.size() == 0 && tx_start) build_frame(byte2send);
            if (q_pin.size() > 0) begin
                exp_pin  = q_pin.pop_front();
                exp_done = q_done.pop_front();
            end else begin
                exp_pin  = 1'b1;
                exp_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_tx_pin", {31'd0, tx_pin}, {31'd0, exp_pin});
            check("model_tx_done", {31'd0, tx_done}, {31'd0, exp_done});
        end
    end

    // Pulse tx_start for one edge, then sample the line mid-bit; byte2send is
    // scrambled right after acceptance and an optional extra request is injected.
    task automatic run_frame(input logic [7:0] b, input int inj_at, input logic [7:0] inj_b,
                             output logic [NBITS-1:0] got, output int done_at, output int n_done);
        got     = '0;
        done_at = -1;
        n_done  = 0;
        byte2send = b;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start  = 1'b0;
        byte2send = ~b;
        for (int j = 0; j < FRAME + 4; j++) begin
            for (int k = 0; k < NBITS; k++)
                if (j == k * CPB + CPB - 1) got[k] = tx_pin;
            if (tx_done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = j;
            end
            if (j == inj_at) begin
                tx_start  = 1'b1;
                byte2send = inj_b;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [NBITS-1:0] got;
        int done_at;
        int n_done;
        int first_done;
        int second_done;

        rst = 1'b1;
        tx_start = 1'b0;
        byte2send = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_tx_pin", {31'd0, tx_pin}, 32'd1);
        check("reset_tx_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_frame(8'h9A, -1, 8'h00, got, done_at, n_done);
        check("frame_9A_bits", 32'(got), 32'(LIT_9A));
        check("frame_9A_done_latency", done_at, FRAME);
        check("frame_9A_done_count", n_done, 1);
        repeat (3) @(negedge clk);
        check("idle_after_9A", {31'd0, tx_pin}, 32'd1);

        run_frame(8'h01, -1, 8'h00, got, done_at, n_done);
        check("frame_01_bits", 32'(got), 32'(LIT_01));

        run_frame(8'h3C, 5, 8'hA5, got, done_at, n_done);
        check("ignored_start_bits", 32'(got), 32'(LIT_3C));
        check("ignored_start_done_count", n_done, 1);
        repeat (2) @(negedge clk);

        // Continuous request: frames repeat every FRAME+1 cycles.
        byte2send = 8'h55;
        tx_start  = 1'b1;
        n_done = 0;
        first_done = -1;
        second_done = -1;
        @(negedge clk);
        for (int j = 0; j < 3 * (FRAME + 1); j++) begin
            if (tx_done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = j;
                else if (second_done < 0) second_done = j;
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        check("held_done_count", n_done, 3);
        check("held_first_done", first_done, FRAME);
        check("held_gap", second_done - first_done, FRAME + 1);
        repeat (FRAME + 4) @(negedge clk);

        // Reset sampled during data bit 3 (frame bit 4).
        byte2send = 8'h9A;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx_pin", {31'd0, tx_pin}, 32'd1);
        check("abort_tx_done", {31'd0, tx_done}, 32'd0);
        n_done = 0;
        for (int j = 0; j < FRAME + 5; j++) begin
            if (tx_done === 1'b1) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", n_done, 0);

        run_frame(8'hFF, -1, 8'h00, got, done_at, n_done);
        check("frame_FF_bits", 32'(got), 32'(LIT_FF));
        check("frame_FF_done_latency", done_at, FRAME);

        // Reset wins over a simultaneous request.
        rst = 1'b1;
        tx_start = 1'b1;
        byte2send = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        tx_start = 1'b0;
        check("rst_start_tx_pin", {31'd0, tx_pin}, 32'd1);
        check("rst_start_tx_done", {31'd0, tx_done}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_start_still_idle", {31'd0, tx_pin}, 32'd1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
